// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_ctrl_if : redirect, decode and instruction-memory signals of fetch   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fetch_ctrl_if;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] JalrTarget;
    logic        Stall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC_F;
    logic        Flush;
    logic        MisalignFault;

    modport slave (
        input  PCSrc, BranchTarget, JalrTarget, Stall, IMemAck, IMemRdata,
        output IMemReq, IMemAddr, Instr, InstrValid, PC_F, Flush, MisalignFault
    );

    modport master (
        output PCSrc, BranchTarget, JalrTarget, Stall, IMemAck, IMemRdata,
        input  IMemReq, IMemAddr, Instr, InstrValid, PC_F, Flush, MisalignFault
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_ctrl : single-outstanding instruction fetch with redirect handling   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
    input  wire logic   CLK,
    input  wire logic   RESET,
    fetch_ctrl_if.slave bus
);
    localparam logic [1:0]  FETCH    = 2'd0;
    localparam logic [1:0]  VALID    = 2'd1;
    localparam logic [1:0]  DISCARD  = 2'd2;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        fault_q, fault_d;

    logic        redirect;
    logic [31:0] raw_tgt;
    logic [31:0] tgt;

    assign redirect = (bus.PCSrc != 2'b00);
    assign raw_tgt  = (bus.PCSrc == 2'b11) ? (bus.JalrTarget & ~32'h1) : bus.BranchTarget;
    assign tgt      = {raw_tgt[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        instr_d = instr_q;
        valid_d = valid_q;
        flush_d = redirect;
        fault_d = fault_q | (redirect & (raw_tgt[1:0] != 2'b00));
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (bus.IMemAck) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = DISCARD;
                    end
                end else if (bus.IMemAck) begin
                    instr_d = bus.IMemRdata;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = tgt;
                    state_d = FETCH;
                end else if (!bus.Stall) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                // The in-flight response belongs to the squashed path; only its ack matters.
                if (bus.IMemAck) begin
                    pc_d    = redirect ? tgt : pend_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_d = tgt;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            pend_q  <= RESET_VECTOR;
            instr_q <= NOP_INSN;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
        end
    end

    // RESET is the only input allowed to reach IMemReq, so no request is issued while held.
    assign bus.IMemReq       = (state_q != VALID) && !RESET;
    assign bus.IMemAddr      = pc_q;
    assign bus.Instr         = instr_q;
    assign bus.InstrValid    = valid_q;
    assign bus.PC_F          = pc_q;
    assign bus.Flush         = flush_q;
    assign bus.MisalignFault = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_ctrl : vector table, corner sequences and randomized model check  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fetch_ctrl;
    localparam logic [31:0] RV  = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK = 1'b0;
    logic RESET;
    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_VECTOR(RV)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [1:0]  pcsrc;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        flush;
        logic        fault;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] pcsrc, input logic [31:0] bt,
                         input logic [31:0] jt, input logic stall, input logic ack,
                         input logic [31:0] rdata);
        RESET            = rst;
        bus.PCSrc        = pcsrc;
        bus.BranchTarget = bt;
        bus.JalrTarget   = jt;
        bus.Stall        = stall;
        bus.IMemAck      = ack;
        bus.IMemRdata    = rdata;
    endtask

    task automatic v(input logic rst, input logic [1:0] pcsrc, input logic [31:0] bt,
                     input logic [31:0] jt, input logic stall, input logic ack,
                     input logic [31:0] rdata, input logic req, input logic [31:0] addr,
                     input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                     input logic flush, input logic fault);
        vq.push_back('{rst, pcsrc, bt, jt, stall, ack, rdata, req, addr, valid, instr, pc, flush, fault});
    endtask

    task automatic cmp_all(input int idx, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                           input logic flush, input logic fault);
        chk("IMemReq", idx, 32'(bus.IMemReq), 32'(req));
        chk("IMemAddr", idx, bus.IMemAddr, addr);
        chk("InstrValid", idx, 32'(bus.InstrValid), 32'(valid));
        chk("Instr", idx, bus.Instr, instr);
        chk("PC_F", idx, bus.PC_F, pc);
        chk("Flush", idx, 32'(bus.Flush), 32'(flush));
        chk("MisalignFault", idx, 32'(bus.MisalignFault), 32'(fault));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference model state: PC, held instruction, and redirects seen while a request is in flight
    logic [31:0] m_pc, m_instr;
    logic        m_have, m_flush, m_fault;
    logic [31:0] m_redir[$];

    initial begin
        int nvalid;
        drive(1, 0, 0, 0, 0, 0, 0);

        // reset, then request with one wait cycle and ack
        v(1,0,0,0,0,0,0,                           0,RV,0,NOP,RV,0,0);
        v(1,2'd1,32'h12345678,0,1,1,32'hAAAA,      0,RV,0,NOP,RV,0,0);
        v(0,0,0,0,0,0,0,                           1,RV,0,NOP,RV,0,0);
        v(0,0,0,0,0,1,32'h00500093,                0,RV,1,32'h00500093,RV,0,0);
        // three stall cycles then consume
        v(0,0,0,0,1,0,0,                           0,RV,1,32'h00500093,RV,0,0);
        v(0,0,0,0,1,0,0,                           0,RV,1,32'h00500093,RV,0,0);
        v(0,0,0,0,1,0,0,                           0,RV,1,32'h00500093,RV,0,0);
        v(0,0,0,0,0,0,0,                           1,32'h00400004,0,32'h00500093,32'h00400004,0,0);
        v(0,0,0,0,0,1,32'h11111111,                0,32'h00400004,1,32'h11111111,32'h00400004,0,0);
        v(0,0,0,0,0,0,0,                           1,32'h00400008,0,32'h11111111,32'h00400008,0,0);
        // branch while request to 0x00400008 is waiting
        v(0,2'd1,32'h00400100,0,0,0,0,             1,32'h00400008,0,32'h11111111,32'h00400008,1,0);
        v(0,0,0,0,0,0,0,                           1,32'h00400008,0,32'h11111111,32'h00400008,0,0);
        v(0,0,0,0,0,1,32'hDEADBEEF,                1,32'h00400100,0,32'h11111111,32'h00400100,0,0);
        v(0,0,0,0,0,1,32'h22222222,                0,32'h00400100,1,32'h22222222,32'h00400100,0,0);
        // misaligned jalr beats stall in VALID
        v(0,2'd3,0,32'h00400203,1,0,0,             1,32'h00400200,0,32'h22222222,32'h00400200,1,1);
        v(0,0,0,0,0,0,0,                           1,32'h00400200,0,32'h22222222,32'h00400200,0,1);
        // two redirects during DISCARD, latest wins
        v(0,2'd1,32'h00400040,0,0,0,0,             1,32'h00400200,0,32'h22222222,32'h00400200,1,1);
        v(0,2'd1,32'h00400080,0,0,0,0,             1,32'h00400200,0,32'h22222222,32'h00400200,1,1);
        v(0,0,0,0,0,1,32'h33333333,                1,32'h00400080,0,32'h22222222,32'h00400080,0,1);
        v(0,0,0,0,0,1,32'h44444444,                0,32'h00400080,1,32'h44444444,32'h00400080,0,1);
        // reset clears fault; wrap at top of address space
        v(1,0,0,0,0,0,0,                           0,RV,0,NOP,RV,0,0);
        v(0,2'd1,32'hFFFFFFFC,0,0,0,0,             1,RV,0,NOP,RV,1,0);
        v(0,0,0,0,0,1,32'h55555555,                1,32'hFFFFFFFC,0,NOP,32'hFFFFFFFC,0,0);
        v(0,0,0,0,0,1,32'h66666666,                0,32'hFFFFFFFC,1,32'h66666666,32'hFFFFFFFC,0,0);
        v(0,0,0,0,0,0,0,                           1,32'h00000000,0,32'h66666666,32'h00000000,0,0);
        // reset mid-request overrides redirect and ack; late ack accepted afterwards
        v(1,2'd1,32'h12345678,0,0,1,32'h77777777,  0,RV,0,NOP,RV,0,0);
        v(0,0,0,0,0,1,32'h88888888,                0,RV,1,32'h88888888,RV,0,0);
        v(0,0,0,0,0,0,0,                           1,32'h00400004,0,32'h88888888,32'h00400004,0,0);
        // PCSrc=10 acts as PC-relative; redirect with same-cycle ack drops the data
        v(0,2'd2,32'h00400300,0,0,1,32'h99999999,  1,32'h00400300,0,32'h88888888,32'h00400300,1,0);

        @(negedge CLK);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].pcsrc, vq[i].bt, vq[i].jt, vq[i].stall, vq[i].ack, vq[i].rdata);
            @(posedge CLK);
            @(negedge CLK);
            cmp_all(i, vq[i].req, vq[i].addr, vq[i].valid, vq[i].instr, vq[i].pc, vq[i].flush, vq[i].fault);
        end

        // zero-wait memory: one instruction every two cycles
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        @(negedge CLK);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'hC0DE0000 + 32'(i));
            @(posedge CLK);
            @(negedge CLK);
            if (bus.InstrValid) nvalid++;
        end
        chk("throughput_count", 0, 32'(nvalid), 32'd4);
        chk("throughput_pc", 0, bus.PC_F, RV + 32'd16);

        // randomized run against the reference model
        for (int c = 0; c < 3000; c++) begin
            logic        r, st, ak;
            logic [1:0]  ps;
            logic [31:0] bt, jt, rd, raw, aligned;
            r  = (c == 0) || ($urandom_range(0, 149) == 0);
            ps = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) bt = 32'hFFFFFFF0 + {28'd0, 4'($urandom_range(0, 15))};
            st = ($urandom_range(0, 9) < 4);
            ak = ($urandom_range(0, 1) == 1);
            rd = $urandom;
            drive(r, ps, bt, jt, st, ak, rd);
            @(posedge CLK);

            if (r) begin
                m_pc = RV; m_instr = NOP; m_have = 0; m_flush = 0; m_fault = 0;
                m_redir.delete();
            end else begin
                raw     = (ps == 2'b11) ? (jt & ~32'h1) : bt;
                aligned = raw - {30'd0, raw[1:0]};
                m_flush = (ps != 2'b00);
                if (m_flush && raw[1:0] != 2'b00) m_fault = 1;
                if (m_have) begin
                    if (m_flush) begin
                        m_have = 0; m_pc = aligned;
                    end else if (!st) begin
                        m_have = 0; m_pc = m_pc + 32'd4;
                    end
                end else begin
                    if (m_flush) m_redir.push_back(aligned);
                    if (ak) begin
                        if (m_redir.size() > 0) begin
                            m_pc = m_redir[$];
                            m_redir.delete();
                        end else begin
                            m_instr = rd; m_have = 1;
                        end
                    end
                end
            end

            @(negedge CLK);
            cmp_all(1000 + c, !m_have && !r, m_pc, m_have, m_instr, m_pc, m_flush, m_fault);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
